// File: rtl/led_sequencer.sv
// Parametrised LED sequencer: prescaled tick, up/down/bounce/hold state index, one-hot LED decode.
// Optional thermometer (bar graph) display enabled by defining LED_SEQUENCER_BAR_EN.
module led_sequencer #(
    parameter int N_LEDS   = 8,
    parameter int IDX_W    = 3,
    parameter int PRESCALE = 4,
    parameter int PS_W     = 26
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [1:0]        mode,
    input  logic              load,
    input  logic [IDX_W-1:0]  load_idx,
`ifdef LED_SEQUENCER_BAR_EN
    input  logic              bar,
`endif
    output logic [IDX_W-1:0]  state,
    output logic [N_LEDS-1:0] Led,
    output logic              tick,
    output logic              wrap
);

    typedef enum logic [1:0] {
        MODE_UP     = 2'b00,
        MODE_DOWN   = 2'b01,
        MODE_BOUNCE = 2'b10,
        MODE_HOLD   = 2'b11
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    localparam logic [PS_W-1:0]  PS_LAST   = PS_W'(PRESCALE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_LEDS - 1);
    localparam logic [IDX_W-1:0] IDX_PENUL = IDX_W'(N_LEDS - 2);
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

    logic [PS_W-1:0]  ps_cnt_q, ps_cnt_d;
    logic [IDX_W-1:0] state_q, state_d;
    dir_e             dir_q, dir_d;
    logic             tick_q, tick_d;
    logic             wrap_q, wrap_d;
    logic             ps_hit;

    always_comb begin
        ps_hit   = en && (ps_cnt_q == PS_LAST);
        ps_cnt_d = ps_cnt_q;
        state_d  = state_q;
        dir_d    = dir_q;
        tick_d   = ps_hit;
        wrap_d   = 1'b0;

        if (en) begin
            ps_cnt_d = ps_hit ? '0 : ps_cnt_q + PS_W'(1);
        end

        // Preload outranks the tick: the tick still pulses, but the index comes from load_idx.
        if (load) begin
            state_d  = (load_idx > IDX_LAST) ? IDX_LAST : load_idx;
            ps_cnt_d = '0;
            dir_d    = DIR_UP;
        end else if (ps_hit) begin
            case (mode_e'(mode))
                MODE_UP: begin
                    dir_d = DIR_UP;
                    if (state_q == IDX_LAST) begin
                        state_d = '0;
                        wrap_d  = 1'b1;
                    end else begin
                        state_d = state_q + IDX_ONE;
                    end
                end
                MODE_DOWN: begin
                    dir_d = DIR_DOWN;
                    if (state_q == '0) begin
                        state_d = IDX_LAST;
                        wrap_d  = 1'b1;
                    end else begin
                        state_d = state_q - IDX_ONE;
                    end
                end
                MODE_BOUNCE: begin
                    if (dir_q == DIR_UP) begin
                        if (state_q == IDX_LAST) begin
                            state_d = IDX_PENUL;
                            dir_d   = DIR_DOWN;
                            wrap_d  = 1'b1;
                        end else begin
                            state_d = state_q + IDX_ONE;
                        end
                    end else begin
                        if (state_q == '0) begin
                            state_d = IDX_ONE;
                            dir_d   = DIR_UP;
                            wrap_d  = 1'b1;
                        end else begin
                            state_d = state_q - IDX_ONE;
                        end
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ps_cnt_q <= '0;
            state_q  <= '0;
            dir_q    <= DIR_UP;
            tick_q   <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            ps_cnt_q <= ps_cnt_d;
            state_q  <= state_d;
            dir_q    <= dir_d;
            tick_q   <= tick_d;
            wrap_q   <= wrap_d;
        end
    end

    always_comb begin
        Led = '0;
        for (int i = 0; i < N_LEDS; i++) begin
`ifdef LED_SEQUENCER_BAR_EN
            Led[i] = bar ? (state_q >= IDX_W'(i)) : (state_q == IDX_W'(i));
`else
            Led[i] = (state_q == IDX_W'(i));
`endif
        end
    end

    assign state = state_q;
    assign tick  = tick_q;
    assign wrap  = wrap_q;

endmodule
